pairwise_product_stream: RTL and testbench
==========================================

Name: pairwise_product_stream

Overview:
- Streaming 8-bit × 8-bit unsigned multiplier block, top-level CHIP of the product datapath.
- Accepts one 8-bit sample per clock while a stream is active.
- Emits the 16-bit product of each sample with the immediately preceding sample, with a ready flag marking valid output cycles.
- Fixed pipeline latency.

Parameters:
- LAT, 2, cycles from the sample-capture edge to the output-register update (pipeline depth; fixed at 2 for this chip).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in  input  8  unsigned sample data; driven shortly after a rising edge, stable for the following edge.
- start  input  1  stream-active strobe; high for the whole stream.
- out  output  16  unsigned product x[n]*x[n-1]; registered.
- ready  output  1  high while out holds a valid product; registered.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (reset_n=0, any time, including mid-stream):
  - clears all registers immediately;
  - out=16'h0000, ready=0, sample/previous-sample registers=0, valid pipeline=0.
  - After release, the block waits for start.
- Capture qualification:
  - start_d is start registered on each rising edge.
  - On a rising edge where start_d=1, in is captured as sample x[n].
  - The first captured sample is therefore taken one edge after the edge that first sees start=1.
  - Capture stops one edge after the edge that first sees start=0.
  - A start pulse high for N edges yields exactly N captured samples.
- Previous sample:
  - prev holds the last captured sample.
  - prev is cleared to 0 on every edge without a capture, so the first product of every burst is x[0]*0 = 0.
- Arithmetic:
  - out = x[n] × x[n-1], both unsigned 8-bit, full 16-bit result, no truncation or saturation.
  - Maximum is 8'hFF × 8'hFF = 16'hFE01.
- Pipeline:
  - Edge E captures x[n].
  - Edge E+1 registers partial products (split the 8×8 array into two halves of 4 multiplier bits).
  - Edge E+2 registers the sum into out.
  - Sample valid propagates alongside; ready is the stage-2 valid.
- Ready behaviour:
  - ready is high for exactly as many consecutive cycles as samples captured in the burst, starting 2 edges after the first capture.
  - ready falls on the edge after the last valid product.
  - out is stable between rising edges; safe to sample on the falling edge.
- Idle output: when ready=0, out holds its last value. Consumers ignore out when ready=0.
- start toggling mid-stream:
  - each gap ends the burst (prev cleared); ready shows a matching gap 2 cycles later.
  - The next burst begins with product 0.
- in changes while no capture is qualified are ignored.

Test Plan:
- Reset check: assert reset_n=0 mid-cycle with arbitrary in/start → out=0000, ready=0 immediately, held until release.
- Basic stream:
  - start high for 4 edges, samples 03,05,FF,02 → ready high 4 cycles starting 2 edges after first capture;
  - out = 0000, 000F, 04FB, 01FE.
- Extremes: samples FF,FF,00,FF,01 → out = 0000, FE01, 0000, 0000, 00FF.
- Long burst latency/count:
  - start raised at mid-cycle 10.5, 3000 random samples driven 0.1 cycle after each edge, start lowered 0.5 cycle after the last;
  - ready rises after edge 14, stays high exactly 3000 cycles;
  - each out matches the golden x[n]*x[n-1] model;
  - ready returns to 0.
- Gap in start: burst A,B, start low 1 edge, burst C,D → outputs 0, A*B, then ready gap, then 0, C*D.
- Reset mid-stream: drop reset_n during burst → outputs cleared at once; a new burst after release starts with product 0 and the correct latency.

Source files
------------

// File: rtl/pairwise_product_stream.sv
// Streaming 8x8 unsigned multiplier: each captured sample is multiplied by the
// previous one in the same burst. The product is ready two edges after the capture.
module pairwise_product_stream #(
    parameter int unsigned LAT = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  in,
    input  logic        start,
    output logic [15:0] out,
    output logic        ready
);

    logic            start_q;
    logic            cap_q;
    logic [7:0]      sample_q, sample_d;
    logic [7:0]      prev_q, prev_d;
    logic [11:0]     pp_lo_q, pp_lo_d;
    logic [11:0]     pp_hi_q, pp_hi_d;
    logic [LAT-1:0]  valid_q, valid_d;
    logic [15:0]     out_q, out_d;

    always_comb begin
        // Edges without a capture zero both samples, so a new burst multiplies by 0.
        sample_d = 8'h00;
        prev_d   = 8'h00;
        if (start_q) begin
            sample_d = in;
            prev_d   = sample_q;
        end

        // Split the multiplier into two 4-bit halves; recombined in the next stage.
        pp_lo_d = {4'h0, sample_q} * {8'h00, prev_q[3:0]};
        pp_hi_d = {4'h0, sample_q} * {8'h00, prev_q[7:4]};

        valid_d = {valid_q[LAT-2:0], cap_q};

        out_d = out_q;
        if (valid_q[0]) begin
            out_d = {4'h0, pp_lo_q} + {pp_hi_q, 4'h0};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            start_q  <= 1'b0;
            cap_q    <= 1'b0;
            sample_q <= 8'h00;
            prev_q   <= 8'h00;
            pp_lo_q  <= 12'h000;
            pp_hi_q  <= 12'h000;
            valid_q  <= '0;
            out_q    <= 16'h0000;
        end else begin
            start_q  <= start;
            cap_q    <= start_q;
            sample_q <= sample_d;
            prev_q   <= prev_d;
            pp_lo_q  <= pp_lo_d;
            pp_hi_q  <= pp_hi_d;
            valid_q  <= valid_d;
            out_q    <= out_d;
        end
    end

    assign out   = out_q;
    assign ready = valid_q[LAT-1];

endmodule

// File: tb/tb_pairwise_product_stream.sv
// Scoreboard bench for pairwise_product_stream: each burst pushes its expected
// products, tagged with the cycle on which they must appear, and a negedge monitor checks them.
module tb_pairwise_product_stream;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  din;
    logic [15:0] dout;
    logic        ready;

    always #5 clock = ~clock;

    pairwise_product_stream #(.LAT(2)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .in      (din),
        .start   (start),
        .out     (dout),
        .ready   (ready)
    );

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] stim[$];
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Any cycle without a tagged expectation must show ready low.
    always @(negedge clock) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                check("ready_valid", 32'(ready), 1);
                check("product", 32'(dout), e.val);
            end else begin
                check("ready_idle", 32'(ready), 0);
            end
        end
    end

    // Call at posedge+1. Edge k first sees start=1; sample i is captured at edge k+1+i
    // and its product is visible after edge k+3+i.
    task automatic burst();
        int k;
        int prevx;
        int n;
        n     = stim.size();
        start = 1'b1;
        k     = cyc + 1;
        prevx = 0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{k + 3 + i, int'(stim[i]) * prevx});
            prevx = int'(stim[i]);
        end
        @(posedge clock); #1;
        for (int i = 0; i < n; i++) begin
            din   = stim[i];
            start = (i + 1 < n);
            @(posedge clock); #1;
        end
        din = 8'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            din = 8'($urandom);
        end
    endtask

    task automatic rand_stim(input int len);
        stim.delete();
        for (int i = 0; i < len; i++) stim.push_back(8'($urandom));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1;
        start   = 1'b0;
        din     = 8'h00;
        #2 reset_n = 1'b0;
        #1;
        check("reset_out", 32'(dout), 0);
        check("reset_ready", 32'(ready), 0);
        start = 1'b1;
        din   = 8'h5A;
        repeat (3) begin
            @(negedge clock);
            check("reset_hold_out", 32'(dout), 0);
            check("reset_hold_ready", 32'(ready), 0);
        end
        @(posedge clock); #3;
        start   = 1'b0;
        reset_n = 1'b1;
        @(posedge clock); #1;
        mon_en = 1'b1;
        idle(2);

        stim = '{8'h03, 8'h05, 8'hFF, 8'h02};
        burst();
        idle(4);

        stim = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h01};
        burst();
        idle(4);

        // Two bursts separated by a single low edge of start.
        rand_stim(2);
        burst();
        rand_stim(2);
        burst();
        idle(4);

        repeat (20) begin
            rand_stim($urandom_range(1, 8));
            burst();
            idle($urandom_range(0, 3));
        end
        idle(4);

        rand_stim(3000);
        burst();
        idle(5);

        // Reset in the middle of a burst; the monitor is paused because no products are expected.
        mon_en = 1'b0;
        start  = 1'b1;
        repeat (6) begin
            din = 8'($urandom);
            @(posedge clock); #1;
        end
        #2;
        check("ready_before_reset", 32'(ready), 1);
        reset_n = 1'b0;
        #1;
        check("midreset_out", 32'(dout), 0);
        check("midreset_ready", 32'(ready), 0);
        repeat (3) begin
            @(negedge clock);
            check("midreset_hold_out", 32'(dout), 0);
            check("midreset_hold_ready", 32'(ready), 0);
        end
        @(posedge clock); #3;
        start   = 1'b0;
        reset_n = 1'b1;
        @(posedge clock); #1;
        mon_en = 1'b1;
        idle(1);
        rand_stim(6);
        burst();
        idle(6);

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
